stack_arbiter: RTL and testbench

//  Shares one LIFO stack (D_WIDTH x DEPTH, push/pop, combinational pop data) among NUM_REQ

---
 rtl/stack_arbiter.sv | 175 +++++++++++++++++
 tb/tb_stack_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack among NUM_REQ requesters.
// Tracks occupancy, returns pop data a cycle after grant, and drains the stack on flush.
module stack_arbiter #(
   parameter int D_WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int NUM_REQ = 4,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int CNT_W = ADDR_WIDTH + 1,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_push,
   input  logic [NUM_REQ*D_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rd_valid,
   output logic [ID_W-1:0]            rd_id,
   output logic [D_WIDTH-1:0]         rd_data,
   input  logic                       flush,
   output logic                       flush_busy,
   output logic                       flush_done,
   output logic [CNT_W-1:0]           count,
   output logic                       stk_w_en,
   output logic [D_WIDTH-1:0]         stk_w_data,
   output logic                       stk_r_en,
   input  logic [D_WIDTH-1:0]         stk_r_data,
   input  logic                       stk_empty,
   output logic                       err
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [ID_W-1:0]      rd_id_q, rd_id_d;
   logic [D_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                 flush_done_q, flush_done_d;
   logic                 err_q, err_d;

   logic [NUM_REQ-1:0]   eligible;
   logic                 found;
   logic [ID_W-1:0]      grant_idx;
   logic                 grant_push;
   logic [D_WIDTH-1:0]   grant_data;
   logic [ID_W:0]        rr_sum;
   logic [ID_W:0]        rr_next;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (state_q == RUN) && !flush &&
                       (req_push[i] ? (count_q < FULL_CNT) : (count_q != '0));
      end
   end

   // Scan starting at rr_ptr with wraparound; the first eligible requester wins
   always_comb begin
      found = 1'b0;
      grant_idx = '0;
      rr_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (rr_sum >= NUM_REQ_W) begin
            rr_sum = rr_sum - NUM_REQ_W;
         end
         if (!found && eligible[rr_sum[ID_W-1:0]]) begin
            found = 1'b1;
            grant_idx = rr_sum[ID_W-1:0];
         end
      end
      grant_push = 1'b0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == grant_idx) begin
            grant_push = req_push[i];
            grant_data = req_wdata[i*D_WIDTH +: D_WIDTH];
         end
      end
      rr_next = {1'b0, grant_idx} + 1'b1;
      if (rr_next == NUM_REQ_W) begin
         rr_next = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rr_ptr_d = rr_ptr_q;
      rd_valid_d = 1'b0;
      rd_id_d = rd_id_q;
      rd_data_d = rd_data_q;
      flush_done_d = 1'b0;
      err_d = err_q | (stk_empty != (count_q == '0));
      req_ready = '0;
      stk_w_en = 1'b0;
      stk_w_data = '0;
      stk_r_en = 1'b0;

      case (state_q)
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
            end else if (found) begin
               req_ready[grant_idx] = 1'b1;
               rr_ptr_d = rr_next[ID_W-1:0];
               if (grant_push) begin
                  stk_w_en = 1'b1;
                  stk_w_data = grant_data;
                  count_d = count_q + 1'b1;
               end else begin
                  stk_r_en = 1'b1;
                  count_d = count_q - 1'b1;
                  rd_valid_d = 1'b1;
                  rd_id_d = grant_idx;
                  rd_data_d = stk_r_data;
               end
            end
         end
         FLUSH: begin
            // Drained entries are popped but never reported on rd_valid
            if (count_q != '0) begin
               stk_r_en = 1'b1;
               count_d = count_q - 1'b1;
            end else begin
               state_d = RUN;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (!rst_n) begin
         req_ready = '0;
         stk_w_en = 1'b0;
         stk_r_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         count_q <= '0;
         rr_ptr_q <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q <= '0;
         rd_data_q <= '0;
         flush_done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rr_ptr_q <= rr_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q <= rd_id_d;
         rd_data_q <= rd_data_d;
         flush_done_q <= flush_done_d;
         err_q <= err_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_id = rd_id_q;
   assign rd_data = rd_data_q;
   assign flush_busy = (state_q == FLUSH);
   assign flush_done = flush_done_q;
   assign count = count_q;
   assign err = err_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a 4-deep behavioural LIFO attached.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_stack_arbiter;

   localparam int D_WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int NUM_REQ = 4;

   logic                       clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_push;
   logic [NUM_REQ*D_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       rd_valid;
   logic [1:0]                 rd_id;
   logic [D_WIDTH-1:0]         rd_data;
   logic                       flush;
   logic                       flush_busy;
   logic                       flush_done;
   logic [2:0]                 count;
   logic                       stk_w_en;
   logic [D_WIDTH-1:0]         stk_w_data;
   logic                       stk_r_en;
   logic [D_WIDTH-1:0]         stk_r_data;
   logic                       stk_empty;
   logic                       err;

   logic [D_WIDTH-1:0]         stackMem [DEPTH];
   logic [2:0]                 stackPtr;
   logic                       forceEmpty;
   int                         checkCount;
   int                         failCount;

   stack_arbiter #(
      .D_WIDTH(D_WIDTH),
      .DEPTH(DEPTH),
      .NUM_REQ(NUM_REQ)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_push(req_push),
      .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rd_valid(rd_valid),
      .rd_id(rd_id),
      .rd_data(rd_data),
      .flush(flush),
      .flush_busy(flush_busy),
      .flush_done(flush_done),
      .count(count),
      .stk_w_en(stk_w_en),
      .stk_w_data(stk_w_data),
      .stk_r_en(stk_r_en),
      .stk_r_data(stk_r_data),
      .stk_empty(stk_empty),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural LIFO with combinational top-of-stack read
   always @(posedge clk) begin
      if (!rst_n) begin
         stackPtr <= '0;
      end else if (stk_w_en && stackPtr < 3'(DEPTH)) begin
         stackMem[stackPtr[1:0]] <= stk_w_data;
         stackPtr <= stackPtr + 3'd1;
      end else if (stk_r_en && stackPtr != 3'd0) begin
         stackPtr <= stackPtr - 3'd1;
      end
   end

   assign stk_r_data = (stackPtr != 3'd0) ? stackMem[stackPtr[1:0] - 2'd1] : '0;
   assign stk_empty = forceEmpty | (stackPtr == 3'd0);

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] push, input logic fl);
      req_valid = valid;
      req_push = push;
      flush = fl;
      #1;
   endtask

   task automatic setData(input int idx, input logic [31:0] value);
      req_wdata[idx*D_WIDTH +: D_WIDTH] = value;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      req_valid = '0;
      req_push = '0;
      flush = 1'b0;
      forceEmpty = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pushFromReq0(input logic [31:0] value);
      setData(0, value);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      tick();
   endtask

   initial begin
      checkCount = 0;
      failCount = 0;
      rst_n = 1'b0;
      req_valid = '0;
      req_push = '0;
      req_wdata = '0;
      flush = 1'b0;
      forceEmpty = 1'b0;

      // Reset values, and no grant while reset is held
      tick();
      setData(0, 32'hA1);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("rst_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_wen", 32'(stk_w_en), 32'h0);
      tick();
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
      checkOutput("rst_rd_id", 32'(rd_id), 32'h0);
      checkOutput("rst_rd_data", rd_data, 32'h0);
      checkOutput("rst_flush_busy", 32'(flush_busy), 32'h0);
      checkOutput("rst_flush_done", 32'(flush_done), 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;

      $display("[TB] back-to-back pushes then pop");
      setData(0, 32'hA1);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("t1_ready0", 32'(req_ready), 32'b0001);
      checkOutput("t1_wen", 32'(stk_w_en), 32'h1);
      checkOutput("t1_wdata", stk_w_data, 32'hA1);
      checkOutput("t1_ren", 32'(stk_r_en), 32'h0);
      tick();
      checkOutput("t1_count1", 32'(count), 32'd1);
      setData(0, 32'hA2);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("t1_ready1", 32'(req_ready), 32'b0001);
      tick();
      checkOutput("t1_count2", 32'(count), 32'd2);
      setData(0, 32'hA3);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("t1_wdata3", stk_w_data, 32'hA3);
      tick();
      checkOutput("t1_count3", 32'(count), 32'd3);
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      checkOutput("t1_pop_ready", 32'(req_ready), 32'b0010);
      checkOutput("t1_pop_ren", 32'(stk_r_en), 32'h1);
      checkOutput("t1_pop_wen", 32'(stk_w_en), 32'h0);
      tick();
      checkOutput("t1_rd_valid", 32'(rd_valid), 32'h1);
      checkOutput("t1_rd_id", 32'(rd_id), 32'd1);
      checkOutput("t1_rd_data", rd_data, 32'hA3);
      checkOutput("t1_count_pop", 32'(count), 32'd2);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("t1_rd_valid_drop", 32'(rd_valid), 32'h0);

      $display("[TB] round-robin pushes to full, pop skips blocked push");
      resetDut();
      for (int i = 0; i < NUM_REQ; i++) setData(i, 32'hB0 + 32'(i));
      applyStimulus(4'b1111, 4'b1111, 1'b0);
      checkOutput("t2_grant0", 32'(req_ready), 32'b0001);
      tick();
      applyStimulus(4'b1110, 4'b1111, 1'b0);
      checkOutput("t2_grant1", 32'(req_ready), 32'b0010);
      tick();
      applyStimulus(4'b1100, 4'b1111, 1'b0);
      checkOutput("t2_grant2", 32'(req_ready), 32'b0100);
      tick();
      applyStimulus(4'b1000, 4'b1111, 1'b0);
      checkOutput("t2_grant3", 32'(req_ready), 32'b1000);
      tick();
      checkOutput("t2_count_full", 32'(count), 32'd4);
      applyStimulus(4'b0101, 4'b0001, 1'b0);
      checkOutput("t2_full_ready", 32'(req_ready), 32'b0100);
      checkOutput("t2_full_wen", 32'(stk_w_en), 32'h0);
      checkOutput("t2_full_ren", 32'(stk_r_en), 32'h1);
      tick();
      checkOutput("t2_rd_valid", 32'(rd_valid), 32'h1);
      checkOutput("t2_rd_id", 32'(rd_id), 32'd2);
      checkOutput("t2_rd_data", rd_data, 32'hB3);
      checkOutput("t2_count", 32'(count), 32'd3);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      $display("[TB] pops blocked when empty, push wins");
      resetDut();
      setData(3, 32'h55);
      applyStimulus(4'b1111, 4'b1000, 1'b0);
      checkOutput("t3_empty_ready", 32'(req_ready), 32'b1000);
      tick();
      checkOutput("t3_count1", 32'(count), 32'd1);
      applyStimulus(4'b0111, 4'b0000, 1'b0);
      checkOutput("t3_pop_ready", 32'(req_ready), 32'b0001);
      tick();
      checkOutput("t3_rd_valid", 32'(rd_valid), 32'h1);
      checkOutput("t3_rd_id", 32'(rd_id), 32'd0);
      checkOutput("t3_rd_data", rd_data, 32'h55);
      checkOutput("t3_count0", 32'(count), 32'd0);
      applyStimulus(4'b0110, 4'b0000, 1'b0);
      checkOutput("t3_empty_pops", 32'(req_ready), 32'b0000);
      checkOutput("t3_empty_ren", 32'(stk_r_en), 32'h0);
      tick();
      checkOutput("t3_no_rd_valid", 32'(rd_valid), 32'h0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      $display("[TB] flush drain from count 3");
      resetDut();
      pushFromReq0(32'hC1);
      pushFromReq0(32'hC2);
      pushFromReq0(32'hC3);
      checkOutput("t4_count3", 32'(count), 32'd3);
      setData(1, 32'hD1);
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      checkOutput("t4_flush_ready", 32'(req_ready), 32'b0000);
      checkOutput("t4_flush_wen", 32'(stk_w_en), 32'h0);
      tick();
      checkOutput("t4_busy", 32'(flush_busy), 32'h1);
      checkOutput("t4_count_hold", 32'(count), 32'd3);
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      for (int j = 0; j < 3; j++) begin
         checkOutput("t4_drain_ren", 32'(stk_r_en), 32'h1);
         checkOutput("t4_drain_ready", 32'(req_ready), 32'b0000);
         tick();
         checkOutput("t4_drain_count", 32'(count), 32'(2 - j));
         checkOutput("t4_drain_rd_valid", 32'(rd_valid), 32'h0);
      end
      checkOutput("t4_last_ren", 32'(stk_r_en), 32'h0);
      checkOutput("t4_last_busy", 32'(flush_busy), 32'h1);
      checkOutput("t4_last_done", 32'(flush_done), 32'h0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("t4_done", 32'(flush_done), 32'h1);
      checkOutput("t4_busy_clear", 32'(flush_busy), 32'h0);
      checkOutput("t4_count_final", 32'(count), 32'd0);
      tick();
      checkOutput("t4_done_pulse", 32'(flush_done), 32'h0);
      checkOutput("t4_err", 32'(err), 32'h0);

      $display("[TB] pop before flush, then reset inside flush");
      resetDut();
      pushFromReq0(32'hE1);
      pushFromReq0(32'hE2);
      pushFromReq0(32'hE3);
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("t5_prepop_valid", 32'(rd_valid), 32'h1);
      checkOutput("t5_prepop_data", rd_data, 32'hE3);
      tick();
      checkOutput("t5_in_flush", 32'(flush_busy), 32'h1);
      checkOutput("t5_count2", 32'(count), 32'd2);
      checkOutput("t5_flush_rd_valid", 32'(rd_valid), 32'h0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_ren", 32'(stk_r_en), 32'h0);
      tick();
      checkOutput("t5_count", 32'(count), 32'd0);
      checkOutput("t5_busy", 32'(flush_busy), 32'h0);
      checkOutput("t5_rd_valid", 32'(rd_valid), 32'h0);
      checkOutput("t5_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      tick();
      checkOutput("t5_err_after", 32'(err), 32'h0);

      $display("[TB] sticky error on empty-flag disagreement");
      resetDut();
      pushFromReq0(32'hF1);
      pushFromReq0(32'hF2);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("t6_count2", 32'(count), 32'd2);
      checkOutput("t6_err_before", 32'(err), 32'h0);
      forceEmpty = 1'b1;
      tick();
      checkOutput("t6_err_set", 32'(err), 32'h1);
      forceEmpty = 1'b0;
      tick();
      tick();
      checkOutput("t6_err_sticky", 32'(err), 32'h1);
      rst_n = 1'b0;
      tick();
      checkOutput("t6_err_reset", 32'(err), 32'h0);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
